// File: rtl/alu_issuer_if.sv
// Command, ALU-side and response signals for the ALU issuer.
// The issuer binds to the slave modport; the command source and ALU stub bind to master.
interface alu_issuer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [1:0] cmd_op;

    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] y;
    logic       parity;
    logic       overflow;
    logic       greater;
    logic       is_eq;
    logic       less;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_y;
    logic [4:0] rsp_flags;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op,
        input  cmd_ready,
        input  a, b, op,
        output y, parity, overflow, greater, is_eq, less,
        input  rsp_valid, rsp_y, rsp_flags, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op,
        output cmd_ready,
        output a, b, op,
        input  y, parity, overflow, greater, is_eq, less,
        output rsp_valid, rsp_y, rsp_flags, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_issuer.sv
// Issues one command at a time to a combinational ALU, holds operands for SETTLE cycles,
// captures the result and flags, and keeps transaction / error counters.
module alu_issuer #(
    parameter int unsigned SETTLE = 1  // legal range 1..7
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_issuer_if.slave  bus,
    input  logic         clr_cnt,
    output logic [15:0]  txn_cnt,
    output logic [7:0]   err_cnt
);

    typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

    state_e      state_q;
    logic [2:0]  settle_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [1:0]  op_q;
    logic [7:0]  rsp_y_q;
    logic [4:0]  rsp_flags_q;
    logic        rsp_err_q;
    logic [15:0] txn_q;
    logic [7:0]  err_q;

    logic        cmd_fire;
    logic        rsp_fire;
    logic [1:0]  cmp_ones;
    logic        cmp_err;

    assign cmd_fire = bus.cmd_valid & cmd_ready_q;
    assign rsp_fire = rsp_valid_q & bus.rsp_ready;
    assign cmp_ones = {1'b0, bus.greater} + {1'b0, bus.is_eq} + {1'b0, bus.less};
    assign cmp_err  = (cmp_ones != 2'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            settle_q    <= 3'd0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            op_q        <= 2'b00;
            rsp_y_q     <= 8'h00;
            rsp_flags_q <= 5'b00000;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_fire) begin
                        a_q         <= bus.cmd_a;
                        b_q         <= bus.cmd_b;
                        op_q        <= bus.cmd_op;
                        settle_q    <= 3'(SETTLE);
                        cmd_ready_q <= 1'b0;
                        state_q     <= StDrive;
                    end
                end
                StDrive: begin
                    // The ALU inputs are only looked at on the edge the count reaches 1.
                    if (settle_q == 3'd1) begin
                        rsp_y_q     <= bus.y;
                        rsp_flags_q <= {bus.parity, bus.overflow, bus.greater, bus.is_eq,
                                        bus.less};
                        rsp_err_q   <= cmp_err;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        settle_q <= settle_q - 3'd1;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txn_q <= 16'h0000;
            err_q <= 8'h00;
        end else if (clr_cnt) begin
            txn_q <= 16'h0000;
            err_q <= 8'h00;
        end else if (rsp_fire) begin
            txn_q <= txn_q + 16'd1;
            if (rsp_err_q && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.op        = op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.rsp_err   = rsp_err_q;
    assign txn_cnt       = txn_q;
    assign err_cnt       = err_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Randomized and directed checks of alu_issuer at SETTLE=1 and SETTLE=4 against a
// transaction-level reference model.
module tb_alu_issuer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       cmd_valid;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [1:0] cmd_op;
    logic [7:0] y;
    logic [4:0] flg;
    logic       rsp_ready;
    logic       clr_cnt;
    logic       sel;

    logic [15:0] txn1;
    logic [15:0] txn4;
    logic [7:0]  err1;
    logic [7:0]  err4;

    alu_issuer_if if1 ();
    alu_issuer_if if4 ();

    assign if1.cmd_valid = cmd_valid;
    assign if1.cmd_a     = cmd_a;
    assign if1.cmd_b     = cmd_b;
    assign if1.cmd_op    = cmd_op;
    assign if1.y         = y;
    assign if1.parity    = flg[4];
    assign if1.overflow  = flg[3];
    assign if1.greater   = flg[2];
    assign if1.is_eq     = flg[1];
    assign if1.less      = flg[0];
    assign if1.rsp_ready = rsp_ready;

    assign if4.cmd_valid = cmd_valid;
    assign if4.cmd_a     = cmd_a;
    assign if4.cmd_b     = cmd_b;
    assign if4.cmd_op    = cmd_op;
    assign if4.y         = y;
    assign if4.parity    = flg[4];
    assign if4.overflow  = flg[3];
    assign if4.greater   = flg[2];
    assign if4.is_eq     = flg[1];
    assign if4.less      = flg[0];
    assign if4.rsp_ready = rsp_ready;

    alu_issuer #(.SETTLE(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (if1),
        .clr_cnt (clr_cnt),
        .txn_cnt (txn1),
        .err_cnt (err1)
    );

    alu_issuer #(.SETTLE(4)) u_dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (if4),
        .clr_cnt (clr_cnt),
        .txn_cnt (txn4),
        .err_cnt (err4)
    );

    // Observation view of whichever instance is under test.
    logic        o_cmd_ready, o_rsp_valid, o_rsp_err;
    logic [7:0]  o_a, o_b, o_rsp_y, o_err;
    logic [1:0]  o_op;
    logic [4:0]  o_rsp_flags;
    logic [15:0] o_txn;

    assign o_cmd_ready = sel ? if4.cmd_ready : if1.cmd_ready;
    assign o_rsp_valid = sel ? if4.rsp_valid : if1.rsp_valid;
    assign o_rsp_err   = sel ? if4.rsp_err   : if1.rsp_err;
    assign o_a         = sel ? if4.a         : if1.a;
    assign o_b         = sel ? if4.b         : if1.b;
    assign o_op        = sel ? if4.op        : if1.op;
    assign o_rsp_y     = sel ? if4.rsp_y     : if1.rsp_y;
    assign o_rsp_flags = sel ? if4.rsp_flags : if1.rsp_flags;
    assign o_txn       = sel ? txn4          : txn1;
    assign o_err       = sel ? err4          : err1;

    int n_checks = 0;
    int n_errors = 0;
    int settle;
    int m_txn;
    int m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        clr_cnt   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        m_txn = 0;
        m_err = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, ".cmd_ready"}, o_cmd_ready, 1);
        check_eq({tag, ".rsp_valid"}, o_rsp_valid, 0);
        check_eq({tag, ".a"}, o_a, 0);
        check_eq({tag, ".b"}, o_b, 0);
        check_eq({tag, ".op"}, o_op, 0);
        check_eq({tag, ".rsp_y"}, o_rsp_y, 0);
        check_eq({tag, ".rsp_flags"}, o_rsp_flags, 0);
        check_eq({tag, ".rsp_err"}, o_rsp_err, 0);
        check_eq({tag, ".txn_cnt"}, o_txn, 0);
        check_eq({tag, ".err_cnt"}, o_err, 0);
    endtask

    // One full transaction: y0 is presented at acceptance and replaced by y1 two cycles later.
    task automatic run_txn(input logic [7:0] ta, input logic [7:0] tb_, input logic [1:0] top,
                           input logic [7:0] y0, input logic [7:0] y1, input logic [4:0] f,
                           input int hold, input bit clr);
        logic [7:0] exp_y;
        logic       exp_e;
        int         lat;
        check_eq("idle.cmd_ready", o_cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_a     = ta;
        cmd_b     = tb_;
        cmd_op    = top;
        y         = y0;
        flg       = f;
        step();
        // Keep a different command on the bus; it must be ignored while busy.
        cmd_a  = ~ta;
        cmd_b  = ~tb_;
        cmd_op = ~top;
        check_eq("acc.a", o_a, ta);
        check_eq("acc.b", o_b, tb_);
        check_eq("acc.op", o_op, top);
        check_eq("acc.cmd_ready", o_cmd_ready, 0);
        lat = 0;
        do begin
            step();
            lat++;
            if (lat == 2) y = y1;
        end while (!o_rsp_valid && lat < 20);
        check_eq("latency", lat, settle);
        exp_y = (settle >= 3) ? y1 : y0;
        exp_e = ($countones(f[2:0]) != 1);
        y   = ~y;
        flg = ~f;
        check_eq("rsp.y", o_rsp_y, exp_y);
        check_eq("rsp.flags", o_rsp_flags, f);
        check_eq("rsp.err", o_rsp_err, exp_e);
        check_eq("rsp.a_hold", o_a, ta);
        for (int i = 0; i < hold; i++) begin
            step();
            check_eq("hold.rsp_valid", o_rsp_valid, 1);
            check_eq("hold.rsp_y", o_rsp_y, exp_y);
            check_eq("hold.cmd_ready", o_cmd_ready, 0);
            check_eq("hold.a", o_a, ta);
        end
        rsp_ready = 1'b1;
        clr_cnt   = clr;
        step();
        rsp_ready = 1'b0;
        clr_cnt   = 1'b0;
        if (clr) begin
            m_txn = 0;
            m_err = 0;
        end else begin
            m_txn = (m_txn + 1) % 65536;
            if (exp_e && m_err < 255) m_err++;
        end
        check_eq("done.rsp_valid", o_rsp_valid, 0);
        check_eq("done.cmd_ready", o_cmd_ready, 1);
        check_eq("done.not_accepted", o_a, ta);
        check_eq("done.txn_cnt", o_txn, m_txn);
        check_eq("done.err_cnt", o_err, m_err);
        cmd_valid = 1'b0;
    endtask

    task automatic rand_txn(input int max_hold);
        run_txn(8'($urandom), 8'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
                5'($urandom), $urandom_range(max_hold, 0), 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cmd_a = 8'h00;
        cmd_b = 8'h00;
        cmd_op = 2'b00;
        y = 8'h00;
        flg = 5'b00000;
        sel = 1'b0;
        settle = 1;
        do_reset();
        check_reset_state("reset1");

        // Worked example: 5+3 with greater/overflow/parity set.
        run_txn(8'h05, 8'h03, 2'b00, 8'h08, 8'h08, 5'b11100, 0, 1'b0);
        check_eq("ex.txn_cnt", o_txn, 1);
        run_txn(8'h10, 8'h20, 2'b01, 8'h30, 8'h30, 5'b00101, 0, 1'b0);
        check_eq("gl.err_cnt", o_err, 1);
        run_txn(8'h44, 8'h44, 2'b10, 8'h00, 8'h00, 5'b00000, 0, 1'b0);
        check_eq("none.err_cnt", o_err, 2);
        run_txn(8'hA5, 8'h5A, 2'b11, 8'hC3, 8'hC3, 5'b01010, 10, 1'b0);
        for (int i = 0; i < 20; i++) rand_txn(3);

        sel = 1'b1;
        settle = 4;
        do_reset();
        check_reset_state("reset4");
        run_txn(8'h01, 8'h02, 2'b01, 8'h11, 8'h22, 5'b00010, 2, 1'b0);
        for (int i = 0; i < 20; i++) rand_txn(3);

        // Reset while in DRIVE abandons the command.
        do_reset();
        cmd_valid = 1'b1;
        cmd_a = 8'h7E;
        cmd_b = 8'h81;
        cmd_op = 2'b11;
        step();
        cmd_valid = 1'b0;
        check_eq("rst_drv.a_before", o_a, 8'h7E);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset_state("rst_drv");
        rand_txn(1);

        sel = 1'b0;
        settle = 1;
        do_reset();
        for (int i = 0; i < 260; i++) begin
            run_txn(8'($urandom), 8'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
                    {2'($urandom), 3'b101}, 0, 1'b0);
        end
        check_eq("sat.err_cnt", o_err, 8'hFF);
        check_eq("sat.txn_cnt", o_txn, 260);
        run_txn(8'h12, 8'h34, 2'b00, 8'h46, 8'h46, 5'b00111, 0, 1'b1);
        check_eq("clr_hs.txn_cnt", o_txn, 0);
        check_eq("clr_hs.err_cnt", o_err, 0);
        run_txn(8'h09, 8'h09, 2'b01, 8'h00, 8'h00, 5'b00110, 1, 1'b0);
        check_eq("post_clr.txn_cnt", o_txn, 1);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check_eq("clr_idle.txn_cnt", o_txn, 0);
        check_eq("clr_idle.err_cnt", o_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning the number of cycles operands are held before results are sampled (legal range 1..7).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state on rising edge
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_op  in  2  ALU opcode
- a  out  8  operand A driven to the ALU
- b  out  8  operand B driven to the ALU
- op  out  2  opcode driven to the ALU
- y  in  8  ALU result
- parity, overflow, greater, is_eq, less  in  1 each  ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_y  out  8  captured result
- rsp_flags  out  5  captured {parity, overflow, greater, is_eq, less}
- rsp_err  out  1  compare flags not one-hot at capture
- clr_cnt  in  1  clears counters
- txn_cnt  out  16  completed responses, wrapping
- err_cnt  out  8  completed responses with rsp_err=1, saturating

Function
REQ-003 SHALL implement FSM states IDLE, DRIVE, RESP.
REQ-004 SHALL drive cmd_ready=1 only in IDLE; every other state SHALL drive cmd_ready=0.
REQ-005 On cmd_valid&&cmd_ready, SHALL register cmd_a/cmd_b/cmd_op onto a/b/op at the same edge, load the settle counter with SETTLE, and enter DRIVE.
REQ-006 In DRIVE, SHALL decrement the settle counter each cycle; when it reaches 1, SHALL capture y and the flags into rsp_y/rsp_flags at that edge and enter RESP.
REQ-007 Latency: with acceptance on edge N, rsp_valid SHALL rise after edge N+SETTLE (SETTLE=1: response visible the cycle after DRIVE).
REQ-008 rsp_err SHALL be captured as 1 when the count of set bits among {greater, is_eq, less} is not exactly 1, else 0.
REQ-009 In RESP, rsp_valid SHALL be 1, and rsp_y/rsp_flags/rsp_err SHALL stay stable until rsp_ready.
REQ-010 On rsp_valid&&rsp_ready, SHALL return to IDLE at the next edge, with rsp_valid low from that edge.
REQ-011 Back-to-back: a new command SHALL NOT be accepted in the cycle of the response handshake; minimum command spacing is SETTLE+2 cycles.
REQ-012 a/b/op SHALL hold their last issued values in IDLE and RESP (no return to zero).
REQ-013 txn_cnt SHALL increment by 1 on each response handshake and wrap from 16'hFFFF to 0.
REQ-014 err_cnt SHALL increment on each response handshake with rsp_err=1 and hold at 8'hFF.
REQ-015 clr_cnt=1 SHALL zero both counters at the next edge; when it coincides with an increment, the clear SHALL win.
REQ-016 cmd_* inputs SHALL be ignored outside IDLE; ALU inputs SHALL be ignored outside the capture edge.

Reset
REQ-017 With rst_n=0 at an edge, SHALL enter IDLE, and SHALL set a, b, op, rsp_y, rsp_flags, rsp_err, txn_cnt, err_cnt to 0 and rsp_valid to 0; cmd_ready SHALL be 1 after reset.
REQ-018 Reset asserted in DRIVE or RESP SHALL abandon the transaction without a handshake and without a counter update.

Verification
REQ-019 SHALL cover these directed scenarios:
- SETTLE=1, cmd a=8'h05 b=8'h03 op=2'b00 accepted at edge 0; stub returns y=8'h08, greater=1, overflow=1, parity=1 -> rsp_valid after edge 1, rsp_y=8'h08, rsp_flags=5'b11100, rsp_err=0, txn_cnt=1 after the handshake.
- Stub drives greater=1 and less=1 -> rsp_err=1, err_cnt increments by 1; stub drives all three low -> rsp_err=1.
- rsp_ready held 0 for 10 cycles -> rsp_valid=1 and rsp_y stable throughout; cmd_ready=0; a new cmd_valid is not accepted.
- SETTLE=4, stub changes y from 8'h11 to 8'h22 two cycles after acceptance -> captured rsp_y=8'h22; rsp_valid after edge 4.
- 256 error responses -> err_cnt=8'hFF held; clr_cnt asserted on the same cycle as a handshake -> both counters read 0.
- rst_n=0 while in DRIVE -> next cycle IDLE, rsp_valid=0, a=b=0, op=0, txn_cnt unchanged at 0.
